// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared datapath types for the fetch-stage predictor
// Direction state encoding keeps the predicted direction in bit 1.
package branch_predictor_pkg;

  localparam int IDX_BITS = 3;
  localparam int TAG_BITS = 30 - IDX_BITS;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    NH = 2'b00,
    NS = 2'b01,
    TS = 2'b10,
    TH = 2'b11
  } bpred_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    word_t               target;
    bpred_t              state;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, EX/MEM training and statistics bundle
// master drives the fetch PC and resolved-branch updates; slave is the predictor.
interface branch_predictor_if;

  branch_predictor_pkg::word_t pc;
  logic                        pred_hit;
  logic                        pred_taken;
  branch_predictor_pkg::word_t pred_npc;
  logic                        upd_en;
  branch_predictor_pkg::word_t upd_pc;
  logic                        upd_taken;
  branch_predictor_pkg::word_t upd_target;
  logic                        upd_mispred;
  branch_predictor_pkg::word_t mispred_cnt;
  branch_predictor_pkg::word_t branch_cnt;

  modport master (
    output pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred,
    input  pred_hit, pred_taken, pred_npc, mispred_cnt, branch_cnt
  );

  modport slave (
    input  pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred,
    output pred_hit, pred_taken, pred_npc, mispred_cnt, branch_cnt
  );

endinterface

// File: rtl/branch_predictor_bpred_next.sv
// rtl/branch_predictor_bpred_next.sv - 2-bit saturating direction state transition
module bpred_next
  import branch_predictor_pkg::*;
(
  input  bpred_t state_i,
  input  logic   taken_i,
  output bpred_t state_o
);

  always_comb begin
    state_o = state_i;
    case (state_i)
      NH:      state_o = taken_i ? NS : NH;
      NS:      state_o = taken_i ? TS : NH;
      TS:      state_o = taken_i ? TH : NS;
      TH:      state_o = taken_i ? TH : TS;
      default: state_o = state_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction state
// Lookup is purely combinational; training writes land on the next rising edge.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = branch_predictor_pkg::IDX_BITS
) (
  input logic                      CLK,
  input logic                      nRST,
  branch_predictor_if.slave        bus
);

  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam int ENTRIES  = 1 << IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    word_t               target;
    bpred_t              state;
  } entry_t;

  entry_t              btb_q [ENTRIES];
  entry_t              rd_entry;
  entry_t              wr_entry;
  entry_t              upd_entry_d;
  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic [TAG_BITS-1:0] wr_tag;
  logic                upd_hit;
  logic                upd_write;
  bpred_t              state_next;
  word_t               branch_cnt_q, branch_cnt_d;
  word_t               mispred_cnt_q, mispred_cnt_d;
  logic                unused_upd_lo;

  assign unused_upd_lo = ^bus.upd_pc[1:0];

  assign rd_idx   = bus.pc[IDX_BITS+1:2];
  assign rd_tag   = bus.pc[31:IDX_BITS+2];
  assign rd_entry = btb_q[rd_idx];

  assign bus.pred_hit   = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign bus.pred_taken = bus.pred_hit && rd_entry.state[1];
  assign bus.pred_npc   = bus.pred_taken ? rd_entry.target : bus.pc + 32'd4;

  assign wr_idx   = bus.upd_pc[IDX_BITS+1:2];
  assign wr_tag   = bus.upd_pc[31:IDX_BITS+2];
  assign wr_entry = btb_q[wr_idx];
  assign upd_hit  = wr_entry.valid && (wr_entry.tag == wr_tag);

  bpred_next u_bpred_next (
    .state_i (wr_entry.state),
    .taken_i (bus.upd_taken),
    .state_o (state_next)
  );

  // A not-taken branch that misses never allocates, so cold code stays out of the BTB.
  always_comb begin
    upd_entry_d = wr_entry;
    upd_write   = 1'b0;
    if (bus.upd_en) begin
      if (upd_hit) begin
        upd_write         = 1'b1;
        upd_entry_d.state = state_next;
        if (bus.upd_taken) begin
          upd_entry_d.target = bus.upd_target;
        end
      end else if (bus.upd_taken) begin
        upd_write          = 1'b1;
        upd_entry_d.valid  = 1'b1;
        upd_entry_d.tag    = wr_tag;
        upd_entry_d.target = bus.upd_target;
        upd_entry_d.state  = TS;
      end
    end
  end

  assign branch_cnt_d  = branch_cnt_q + {31'd0, bus.upd_en};
  assign mispred_cnt_d = mispred_cnt_q + {31'd0, bus.upd_en && bus.upd_mispred};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i].valid  <= 1'b0;
        btb_q[i].tag    <= '0;
        btb_q[i].target <= '0;
        btb_q[i].state  <= NS;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd_write) begin
        btb_q[wr_idx] <= upd_entry_d;
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage branch predictor and branch target buffer (BTB) for the pipelined MIPS datapath.
- Each cycle it looks up the fetch PC and produces the predicted next PC, which feeds the PC register and the if_id_t npc field.
- Branch outcomes resolved in the EX/MEM stage train it via an update port.
- Per-entry direction state uses the 2-bit bpred_t encoding.

Parameters:
- IDX_BITS, 3, log2 of BTB entries (8 entries); index = pc[IDX_BITS+1:2].
- TAG_BITS, 30-IDX_BITS, tag width; tag = pc[31:IDX_BITS+2].

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- pc  input  32  current fetch PC (word_t).
- pred_hit  output  1  valid BTB entry whose tag matches pc.
- pred_taken  output  1  pred_hit and entry state predicts taken.
- pred_npc  output  32  entry target if pred_taken, else pc+4.
- upd_en  input  1  a resolved conditional branch is presented this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  actual branch outcome.
- upd_target  input  32  actual branch target (baddr).
- upd_mispred  input  1  the fetch prediction for this branch was wrong (qualified by upd_en).
- mispred_cnt  output  32  count of upd_en && upd_mispred events.
- branch_cnt  output  32  count of upd_en events.

Behaviour:
- Storage per entry: valid, tag, target (word_t), state (bpred_t).
- Lookup is combinational from pc and the current register contents (zero-cycle latency).
  - Miss gives pred_hit=0, pred_taken=0, pred_npc=pc+4.
- Taken/not-taken decode from state: TH/TS predict taken; NH/NS predict not-taken (state[1]).
- Update is registered and takes effect at the rising CLK edge after upd_en is sampled high.
- Hit on upd_pc (valid and tag match):
  - state advances per the FSM below;
  - if upd_taken, target is overwritten with upd_target; otherwise target is unchanged.
- Miss on upd_pc:
  - upd_taken=1: allocate the indexed entry (direct-mapped replacement) with valid=1, tag, target=upd_target, state=TS.
  - upd_taken=0: no change.
- FSM on taken: NH->NS, NS->TS, TS->TH, TH->TH (saturates).
- FSM on not-taken: TH->TS, TS->NS, NS->NH, NH->NH (saturates).
- Simultaneous lookup and update to the same index in one cycle: lookup returns the pre-update contents; the new contents are visible the next cycle. No bypass.
- Counters:
  - branch_cnt increments by 1 per cycle with upd_en=1.
  - mispred_cnt increments when upd_en && upd_mispred.
  - Both wrap 0xFFFFFFFF->0.
  - upd_mispred is ignored when upd_en=0.
- Reset (asynchronous, any time, including mid-update):
  - all valid=0, state=NS, tag=0, target=0, both counters=0;
  - therefore pred_hit=0, pred_taken=0, pred_npc=pc+4 while nRST=0 and after release until the first allocation.
- pc+4 is a 32-bit add with wraparound: pc=0xFFFFFFFC gives 0x00000000.
- Low two PC bits are ignored for index and tag.

Decomposition:
- Add to dp_types_pkg:
  - btb_entry_t packed struct {logic valid; logic [TAG_BITS-1:0] tag; word_t target; bpred_t state};
  - default IDX_BITS localparam.
- bpred_t already lives there.
- One sub-module, bpred_next: combinational next-state function (bpred_t state, logic taken -> bpred_t), unit-testable in isolation.

Test Plan:
- Reset, then pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_npc=0x00000044; both counters 0.
- upd_en with upd_pc=0x40, upd_taken=1, upd_target=0x100, then next cycle pc=0x40 -> pred_hit=1, pred_taken=1 (TS), pred_npc=0x100, branch_cnt=1.
- Same branch resolves taken twice more, then not-taken 4 times:
  - states TS->TH->TH->TS->NS->NH->NH;
  - pred_taken goes 0 after the second not-taken;
  - pred_npc=0x44 thereafter.
- Aliasing: allocate 0x40 (taken, 0x100), then upd_pc=0x60 (same index with IDX_BITS=3, different tag), taken, 0x200 -> lookup 0x40 misses (0x44); lookup 0x60 hits with 0x200.
- Not-taken miss: upd_pc=0x80, upd_taken=0 -> no allocation; lookup 0x80 gives pred_hit=0.
- Same-cycle lookup/update at 0x40 (entry TS, taken) with upd_taken=0:
  - that cycle pred_taken=1;
  - next cycle state=NS and pred_taken=0;
  - assert nRST low mid-sequence -> all outputs return to the reset values above asynchronously.
- 3 updates with upd_mispred=1 and 2 with upd_mispred=0, plus one cycle with upd_mispred=1 while upd_en=0 -> mispred_cnt=3, branch_cnt=5.
